word_uart_tx: RTL
=================

# word_uart_tx

Transmits the three-letter word held by the letter-entry buffer as ASCII over a UART line (8N1, LSB first). On a rising edge of `send`, it snapshots `letter1`..`letter3`, serializes the leading non-space letters, then appends a carriage return (0x0D). It sits between the letter-entry block and the board's USB-UART TX pin and is the outbound counterpart of the letter-entry buffer.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `send`, input, 1: level request. A rising edge starts a transmission.
- `letter1`, input, 8: first ASCII letter.
- `letter2`, input, 8: second ASCII letter.
- `letter3`, input, 8: third ASCII letter.
- `tx`, output, 1: UART serial out, idle high. Registered.
- `busy`, output, 1: high while a word is in flight. Registered.
- `done`, output, 1: one-cycle pulse when the final stop bit completes. Registered.

## Operation
- Edge detect: internal `flagSend` is set whenever `send`=1 and cleared whenever `send`=0.
  - A trigger requires `send`=1, `flagSend`=0 and state IDLE.
  - A rising edge during busy only sets the flag. Holding `send` high past completion does not retrigger.
- On trigger:
  - Latch the three letters into a 3-byte word register.
  - Compute `count` (0..3), the number of leading letters not equal to 0x20. Scanning stops at the first space.
  - The character sequence is the first `count` letters followed by 0x0D. There are always `count`+1 frames.
- States:
  - IDLE: `tx`=1, `busy`=0. On trigger, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles, tracked by a 3-bit index. Then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. If characters remain, advance the char index and go to START with no idle gap. Otherwise pulse `done` and go to IDLE.
- The baud counter is sized `$clog2(CLKS_PER_BIT)` bits. It counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary.
- Input letters are ignored after latching. Changes mid-word have no effect on the bytes sent.
- Reset (`reset`=0), asynchronous, at any time including mid-frame:
  - `tx`=1, `busy`=0, `done`=0, state IDLE.
  - All counters, the char index and `flagSend` cleared.
  - The partial frame is abandoned.
- `send` already high at reset release counts as a rising edge, because the flag is clear.

## Timing
- Trigger is sampled at clock edge N. At edge N+1, `tx`=0 (start bit begins) and `busy`=1.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles. Word length is (`count`+1)·10·`CLKS_PER_BIT` cycles.
- The start bit of the next character follows the previous stop bit's last cycle directly.
- Last stop bit ends at cycle E. In the same cycle:
  - `done`=1 for exactly one cycle.
  - `busy` goes 0.
  - The state is IDLE.
- The earliest retrigger is the cycle after `done`, and only if `send` has been low at some sampled edge since the last trigger.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset:
  - Stimulus: assert `reset`=0 with random inputs.
  - Response: `tx`=1, `busy`=0, `done`=0, asynchronously, before any clock edge.
- Full word:
  - Stimulus: letters "C","A","T" (0x43, 0x41, 0x54); `send` low then high.
  - Response: the line decodes as 0x43, 0x41, 0x54, 0x0D.
  - Response: `busy` is high for 160 cycles.
  - Response: one `done` pulse at the end.
- Space stop:
  - Stimulus: letters "H"," ","I".
  - Response: only 0x48, 0x0D (80 cycles). "I" is never sent.
- All spaces:
  - Stimulus: letters 0x20, 0x20, 0x20; send.
  - Response: only 0x0D (40 cycles), then `done`.
- Held send and mid-word changes:
  - Stimulus: send "DOG" and keep `send` high through `done`; change the letters to "XYZ" mid-word.
  - Response: sends 0x44, 0x4F, 0x47, 0x0D, with no retransmit while `send` stays high.
  - Stimulus: drop `send`, then raise it again.
  - Response: sends 0x58, 0x59, 0x5A, 0x0D.
- Reset mid-frame:
  - Stimulus: assert reset during data bit 3 of the first char.
  - Response: `tx`=1 immediately, `busy`=0, no `done`.
  - Stimulus: after release, with `send` low, raise `send`.
  - Response: a complete new word is sent from the start bit.

Source files
------------

// File: rtl/word_uart_tx.sv
// -----------------------------------------------------------------------------
// word_uart_tx
//
// Sends the three-letter word from the letter-entry buffer as ASCII over an
// 8N1 UART line, LSB first. A rising edge on `send` snapshots the letters.
// The block then sends the leading non-space letters, followed by a carriage
// return (0x0D). Each word therefore carries count+1 frames, where count is
// 0..3. Back-to-back frames have no idle gap between them.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit (>= 2)
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   send     - level request; a rising edge (seen while idle) starts a word
//   letter1  - first ASCII letter
//   letter2  - second ASCII letter
//   letter3  - third ASCII letter
//   tx       - UART serial output, idle high (registered)
//   busy     - high while a word is in flight (registered)
//   done     - one-cycle pulse as the final stop bit completes (registered)
// -----------------------------------------------------------------------------
module word_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] letter1,
    input  logic [7:0] letter2,
    input  logic [7:0] letter3,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Counts the leading letters that are not spaces. The scan stops at the
    // first space, so a later non-space letter never counts.
    function automatic logic [1:0] lead_count(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c);
        logic [1:0] n;
        if (a == ASCII_SPACE) begin
            n = 2'd0;
        end else if (b == ASCII_SPACE) begin
            n = 2'd1;
        end else if (c == ASCII_SPACE) begin
            n = 2'd2;
        end else begin
            n = 2'd3;
        end
        return n;
    endfunction

    // Selects the character for frame `idx`. Frames below `cnt` carry the
    // latched letters; the frame at `cnt` is the terminating CR.
    function automatic logic [7:0] pick_char(input logic [23:0] word,
                                             input logic [1:0]  idx,
                                             input logic [1:0]  cnt);
        logic [7:0] ch;
        if (idx < cnt) begin
            case (idx)
                2'd0:    ch = word[7:0];
                2'd1:    ch = word[15:8];
                default: ch = word[23:16];
            endcase
        end else begin
            ch = ASCII_CR;
        end
        return ch;
    endfunction

    state_t          state_r;
    logic [BW-1:0]   baud_r;
    logic [2:0]      bit_idx_r;
    logic [1:0]      char_idx_r;
    logic [1:0]      count_r;
    logic [23:0]     word_r;
    logic [7:0]      char_r;
    logic            flag_send_r;
    logic            tx_r;
    logic            busy_r;
    logic            done_r;

    logic            baud_end_s;
    logic            trigger_s;
    logic [7:0]      next_char_s;
    logic            next_bit_s;

    assign baud_end_s  = (baud_r == BAUD_LAST);
    assign trigger_s   = send & ~flag_send_r & (state_r == ST_IDLE);
    assign next_char_s = pick_char(word_r, char_idx_r, count_r);
    // This is the bit that follows the current data bit. The index wraps
    // after bit 7, but that value is never used, because the frame moves on
    // to the stop bit at that point.
    assign next_bit_s  = char_r[bit_idx_r + 3'd1];

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

    // Tracks the last sampled level of send for rising-edge detection.
    // Because reset clears this flag, a send that is already high when
    // reset releases counts as a fresh edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_send_r <= 1'b0;
        end else begin
            flag_send_r <= send;
        end
    end

    // Main transmit FSM: bit timing, framing, character sequencing and the
    // registered tx/busy/done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            baud_r     <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            char_idx_r <= 2'd0;
            count_r    <= 2'd0;
            word_r     <= 24'd0;
            char_r     <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    baud_r <= BAUD_ZERO;
                    if (trigger_s) begin
                        word_r     <= {letter3, letter2, letter1};
                        count_r    <= lead_count(letter1, letter2, letter3);
                        char_idx_r <= 2'd0;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_START: begin
                    done_r <= 1'b0;
                    if (baud_end_s) begin
                        // Load the character here, so that the word and the
                        // index both come from registers.
                        baud_r    <= BAUD_ZERO;
                        bit_idx_r <= 3'd0;
                        char_r    <= next_char_s;
                        tx_r      <= next_char_s[0];
                        state_r   <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end

                ST_DATA: begin
                    done_r <= 1'b0;
                    if (baud_end_s) begin
                        baud_r <= BAUD_ZERO;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= next_bit_s;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end

                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_r <= BAUD_ZERO;
                        if (char_idx_r == count_r) begin
                            // The CR frame has just finished, so the word is
                            // complete.
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            char_idx_r <= char_idx_r + 2'd1;
                            tx_r       <= 1'b0;
                            done_r     <= 1'b0;
                            state_r    <= ST_START;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                        done_r <= 1'b0;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    baud_r  <= BAUD_ZERO;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
